// File: rtl/eh2_lsu_ecc_scrub_pkg.sv
// SECDED(39,32) helpers shared by the DCCM check/correct path and its correction queue.
// Codeword positions 1..38 follow Hamming order; the top check bit is overall parity.
package eh2_lsu_ecc_scrub_pkg;

    localparam int ECC32_WIDTH = 7;
    localparam int ECC_CW_POS  = 38;

    typedef struct packed {
        logic [31:0] data;
        logic        sb;
        logic        db;
    } ecc32_dec_t;

    // XOR of the Hamming positions of every set data bit (check bits sit at powers of two)
    function automatic logic [5:0] ecc32_syndrome(input logic [31:0] d);
        logic [5:0] s;
        int         di;
        s  = '0;
        di = 0;
        for (int pos = 1; pos <= ECC_CW_POS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[di]) s = s ^ 6'(pos);
                di++;
            end
        end
        return s;
    endfunction

    function automatic logic [ECC32_WIDTH-1:0] ecc32_encode(input logic [31:0] d);
        logic [5:0] h;
        h = ecc32_syndrome(d);
        return {^{d, h}, h};
    endfunction

    function automatic ecc32_dec_t ecc32_decode(input logic [31:0] d, input logic [ECC32_WIDTH-1:0] e);
        ecc32_dec_t r;
        logic [5:0] syn;
        logic       par;
        int         di;
        syn    = ecc32_syndrome(d) ^ e[5:0];
        par    = ^{d, e};
        r.sb   = par;
        r.db   = ~par & (syn != '0);
        r.data = d;
        di     = 0;
        for (int pos = 1; pos <= ECC_CW_POS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (par && (syn == 6'(pos))) r.data[di] = ~d[di];
                di++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/eh2_lsu_ecc_corrq.sv
// Circular correction write-back queue with store-kill compare and head pop/retire.
// Pushes land one cycle later on wb_*; killed head slots retire one per cycle without a write.
module eh2_lsu_ecc_corrq
    import eh2_lsu_ecc_scrub_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = 14,
    parameter int CORR_DEPTH = 4,
    parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_BANKS-1:0]             push_vld,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  push_addr,
    input  logic [NUM_BANKS*32-1:0]          push_data,
    input  logic                             st_wr_valid,
    input  logic [BANK_W-1:0]                st_wr_bank,
    input  logic [ADDR_WIDTH-1:0]            st_wr_addr,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [BANK_W-1:0]                wb_bank,
    output logic [ADDR_WIDTH-1:0]            wb_addr,
    output logic [38:0]                      wb_data,
    output logic                             push_drop
);

    localparam int PW = $clog2(CORR_DEPTH);

    typedef struct packed {
        logic [2:0]            bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
        logic                  vld;
    } corr_t;

    corr_t         slot_q [CORR_DEPTH];
    corr_t         slot_d [CORR_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   cnt_q, cnt_d;
    corr_t         head;
    logic          head_hit, adv;
    int            n_push, n_free;

    assign head    = slot_q[head_q];
    assign wb_bank = head.bank[BANK_W-1:0];
    assign wb_addr = head.addr;
    assign wb_data = {ecc32_encode(head.data), head.data};

    always_comb begin
        slot_d    = slot_q;
        head_d    = head_q;
        push_drop = 1'b0;
        n_push    = 0;
        head_hit  = st_wr_valid && (head.bank == 3'(st_wr_bank)) && (head.addr == st_wr_addr);
        wb_valid  = head.vld & ~head_hit;
        // a killed head still occupies its slot until it retires here
        adv       = (cnt_q != '0) && (!head.vld || (wb_valid && wb_ready));
        for (int s = 0; s < CORR_DEPTH; s++) begin
            if (st_wr_valid && (slot_q[s].bank == 3'(st_wr_bank)) && (slot_q[s].addr == st_wr_addr))
                slot_d[s].vld = 1'b0;
        end
        if (adv) begin
            slot_d[head_q].vld = 1'b0;
            head_d             = head_q + PW'(1);
        end
        n_free = CORR_DEPTH - int'(cnt_q) + int'(adv);
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (push_vld[b]) begin
                if (st_wr_valid && (3'(st_wr_bank) == 3'(b)) && (st_wr_addr == push_addr[b*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    // stale by the time it would be written back
                end else if (n_push < n_free) begin
                    slot_d[tail_q + PW'(n_push)] = '{bank: 3'(b),
                                                     addr: push_addr[b*ADDR_WIDTH +: ADDR_WIDTH],
                                                     data: push_data[b*32 +: 32],
                                                     vld:  1'b1};
                    n_push++;
                end else begin
                    push_drop = 1'b1;
                end
            end
        end
        tail_d = tail_q + PW'(n_push);
        cnt_d  = (PW+1)'(int'(cnt_q) - int'(adv) + n_push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/eh2_lsu_ecc_scrub.sv
// DCCM SECDED decode for NUM_BANKS banks, saturating SEC/DED counters and threshold interrupt.
// Decode is combinational in dc3; corrections queue with one cycle latency, drained via wb_valid/wb_ready.
module eh2_lsu_ecc_scrub
    import eh2_lsu_ecc_scrub_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = 14,
    parameter int CORR_DEPTH = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             scan_mode,
    input  logic                             ecc_disable,
    input  logic [NUM_BANKS-1:0]             rd_valid,
    input  logic                             rd_fault,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  rd_addr,
    input  logic [NUM_BANKS*32-1:0]          rd_data,
    input  logic [NUM_BANKS*7-1:0]           rd_ecc,
    output logic [NUM_BANKS*32-1:0]          sec_data,
    output logic [NUM_BANKS-1:0]             single_err,
    output logic [NUM_BANKS-1:0]             double_err,
    output logic                             any_single,
    output logic                             any_double,
    input  logic                             st_wr_valid,
    input  logic [BANK_W-1:0]                st_wr_bank,
    input  logic [ADDR_WIDTH-1:0]            st_wr_addr,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [BANK_W-1:0]                wb_bank,
    output logic [ADDR_WIDTH-1:0]            wb_addr,
    output logic [38:0]                      wb_data,
    output logic                             corr_overflow,
    output logic [CNT_WIDTH-1:0]             sec_count,
    output logic [CNT_WIDTH-1:0]             ded_count,
    input  logic [CNT_WIDTH-1:0]             err_thresh,
    input  logic                             cnt_clr,
    output logic                             err_irq
);

    localparam int SW = CNT_WIDTH + 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 unused_scan;
    logic                 push_drop;
    logic [3:0]           sec_inc, ded_inc;
    logic [SW-1:0]        sec_sum, ded_sum;
    logic [CNT_WIDTH-1:0] sec_count_q, sec_count_d, ded_count_q, ded_count_d;
    logic                 overflow_q, overflow_d, err_irq_q, err_irq_d;

    assign unused_scan = scan_mode;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ecc32_dec_t dec;
        logic       en;
        assign en                  = rd_valid[b] & ~ecc_disable;
        assign dec                 = ecc32_decode(rd_data[b*32 +: 32], rd_ecc[b*7 +: 7]);
        assign sec_data[b*32 +: 32] = en ? dec.data : rd_data[b*32 +: 32];
        assign single_err[b]       = en & dec.sb & ~rd_fault;
        assign double_err[b]       = en & dec.db;
    end

    assign any_single = |single_err;
    assign any_double = |double_err;

    eh2_lsu_ecc_corrq #(
        .NUM_BANKS  (NUM_BANKS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CORR_DEPTH (CORR_DEPTH),
        .BANK_W     (BANK_W)
    ) u_corrq (
        .clk         (clk),
        .rst         (rst),
        .push_vld    (single_err),
        .push_addr   (rd_addr),
        .push_data   (sec_data),
        .st_wr_valid (st_wr_valid),
        .st_wr_bank  (st_wr_bank),
        .st_wr_addr  (st_wr_addr),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_bank     (wb_bank),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .push_drop   (push_drop)
    );

    always_comb begin
        sec_inc = '0;
        ded_inc = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            sec_inc = sec_inc + 4'(single_err[b]);
            ded_inc = ded_inc + 4'(double_err[b]);
        end
        sec_sum     = SW'(sec_count_q) + SW'(sec_inc);
        ded_sum     = SW'(ded_count_q) + SW'(ded_inc);
        sec_count_d = (sec_sum > SW'(CNT_MAX)) ? CNT_MAX : sec_sum[CNT_WIDTH-1:0];
        ded_count_d = (ded_sum > SW'(CNT_MAX)) ? CNT_MAX : ded_sum[CNT_WIDTH-1:0];
        overflow_d  = overflow_q | push_drop;
        // clearing takes priority over this cycle's events
        if (cnt_clr) begin
            sec_count_d = '0;
            ded_count_d = '0;
            overflow_d  = 1'b0;
        end
        err_irq_d = (err_thresh != '0) && (sec_count_d >= err_thresh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_count_q <= '0;
            ded_count_q <= '0;
            overflow_q  <= 1'b0;
            err_irq_q   <= 1'b0;
        end else begin
            sec_count_q <= sec_count_d;
            ded_count_q <= ded_count_d;
            overflow_q  <= overflow_d;
            err_irq_q   <= err_irq_d;
        end
    end

    assign sec_count     = sec_count_q;
    assign ded_count     = ded_count_q;
    assign corr_overflow = overflow_q;
    assign err_irq       = err_irq_q;

endmodule

// File: tb/tb_eh2_lsu_ecc_scrub.sv
// Bench for eh2_lsu_ecc_scrub: directed scenarios plus randomized traffic against a queue-based model.
module tb_eh2_lsu_ecc_scrub;

    localparam int NB = 2;
    localparam int AW = 14;
    localparam int CD = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst, scan_mode, ecc_disable, rd_fault;
    logic [NB-1:0]     rd_valid;
    logic [NB*AW-1:0]  rd_addr;
    logic [NB*32-1:0]  rd_data;
    logic [NB*7-1:0]   rd_ecc;
    logic [NB*32-1:0]  sec_data;
    logic [NB-1:0]     single_err, double_err;
    logic              any_single, any_double;
    logic              st_wr_valid;
    logic [0:0]        st_wr_bank;
    logic [AW-1:0]     st_wr_addr;
    logic              wb_valid, wb_ready;
    logic [0:0]        wb_bank;
    logic [AW-1:0]     wb_addr;
    logic [38:0]       wb_data;
    logic              corr_overflow;
    logic [CW-1:0]     sec_count, ded_count, err_thresh;
    logic              cnt_clr, err_irq;

    eh2_lsu_ecc_scrub #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .CORR_DEPTH(CD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .scan_mode(scan_mode), .ecc_disable(ecc_disable),
        .rd_valid(rd_valid), .rd_fault(rd_fault), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ecc(rd_ecc),
        .sec_data(sec_data), .single_err(single_err), .double_err(double_err),
        .any_single(any_single), .any_double(any_double),
        .st_wr_valid(st_wr_valid), .st_wr_bank(st_wr_bank), .st_wr_addr(st_wr_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_bank(wb_bank), .wb_addr(wb_addr), .wb_data(wb_data),
        .corr_overflow(corr_overflow), .sec_count(sec_count), .ded_count(ded_count),
        .err_thresh(err_thresh), .cnt_clr(cnt_clr), .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          bank;
        logic [AW-1:0] addr;
        logic [31:0] data;
        bit          vld;
    } ment_t;

    ment_t       mq[$];
    int          m_sec, m_ded;
    bit          m_ovf, m_irq;
    logic [31:0] clean [NB];
    int          flips [NB];

    // Golden check bits: lay data into non-power-of-two Hamming positions, then parity per position bit
    function automatic logic [6:0] gold_ecc(input logic [31:0] d);
        logic [38:0] cw;
        logic [6:0]  e;
        int          di;
        cw = '0;
        di = 0;
        for (int p = 1; p <= 38; p++) begin
            if ($countones(p) != 1) begin
                cw[p] = d[di];
                di++;
            end
        end
        e = '0;
        for (int k = 0; k < 6; k++)
            for (int p = 1; p <= 38; p++)
                if (((p >> k) & 1) == 1) e[k] = e[k] ^ cw[p];
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic bit en_bank(input int b);
        return rd_valid[b] && !ecc_disable;
    endfunction

    function automatic bit exp_single(input int b);
        return en_bank(b) && (flips[b] == 1) && !rd_fault;
    endfunction

    function automatic bit exp_double(input int b);
        return en_bank(b) && (flips[b] == 2);
    endfunction

    function automatic bit st_match(input int bank, input logic [AW-1:0] addr);
        return st_wr_valid && (int'(st_wr_bank) == bank) && (st_wr_addr == addr);
    endfunction

    task automatic drive_bank(input int b, input int nf, input int a, input int bitpos);
        logic [31:0] d;
        logic [38:0] cwv;
        int          i0, i1;
        d   = $urandom;
        cwv = {gold_ecc(d), d};
        i0  = (bitpos >= 0) ? bitpos : int'($urandom_range(0, 38));
        if (nf >= 1) cwv[i0] = ~cwv[i0];
        if (nf == 2) begin
            i1 = (i0 + 1 + int'($urandom_range(0, 37))) % 39;
            cwv[i1] = ~cwv[i1];
        end
        rd_valid[b]          = 1'b1;
        rd_addr[b*AW +: AW]  = AW'(a);
        rd_data[b*32 +: 32]  = cwv[31:0];
        rd_ecc[b*7 +: 7]     = cwv[38:32];
        clean[b]             = d;
        flips[b]             = nf;
    endtask

    task automatic idle();
        rd_valid    = '0;
        rd_fault    = 1'b0;
        ecc_disable = 1'b0;
        st_wr_valid = 1'b0;
        cnt_clr     = 1'b0;
        for (int b = 0; b < NB; b++) flips[b] = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_sec = 0;
        m_ded = 0;
        m_ovf = 1'b0;
        m_irq = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied, then step the DUT
    task automatic model_clock();
        int ns, nd;
        bit adv, drop;
        ns = 0; nd = 0; adv = 1'b0; drop = 1'b0;
        for (int b = 0; b < NB; b++) begin
            ns += int'(exp_single(b));
            nd += int'(exp_double(b));
        end
        if (mq.size() > 0)
            adv = !mq[0].vld || (wb_ready && !st_match(mq[0].bank, mq[0].addr));
        foreach (mq[i]) if (st_match(mq[i].bank, mq[i].addr)) mq[i].vld = 1'b0;
        if (adv) void'(mq.pop_front());
        for (int b = 0; b < NB; b++) begin
            if (exp_single(b) && !st_match(b, rd_addr[b*AW +: AW])) begin
                if (mq.size() < CD) mq.push_back('{b, rd_addr[b*AW +: AW], clean[b], 1'b1});
                else drop = 1'b1;
            end
        end
        if (cnt_clr) begin
            m_sec = 0; m_ded = 0; m_ovf = 1'b0;
        end else begin
            m_sec = (m_sec + ns > 65535) ? 65535 : m_sec + ns;
            m_ded = (m_ded + nd > 65535) ? 65535 : m_ded + nd;
            m_ovf = m_ovf | drop;
        end
        m_irq = (err_thresh != 0) && (m_sec >= int'(err_thresh));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        checks++;
        if ({sec_count, ded_count} !== 32'h0) begin failures++; $display("FAIL reset_counts: got %0d/%0d want 0/0", sec_count, ded_count); end
        checks++;
        if ({corr_overflow, err_irq} !== 2'b00) begin failures++; $display("FAIL reset_flags: got ovf=%b irq=%b want 0/0", corr_overflow, err_irq); end
    endtask

    task automatic test_single_bank1();
        idle(); wb_ready = 1'b0;
        drive_bank(1, 1, 'h21, 5);
        #1;
        checks++;
        if (sec_data[63:32] !== clean[1]) begin failures++; $display("FAIL sb_corrected: got %h want %h", sec_data[63:32], clean[1]); end
        checks++;
        if ({single_err, double_err, any_single} !== 5'b10_00_1) begin failures++; $display("FAIL sb_flags: got se=%b de=%b any=%b want 10/00/1", single_err, double_err, any_single); end
        model_clock();
        idle();
        #1;
        checks++;
        if ({wb_valid, wb_bank, wb_addr} !== {1'b1, 1'b1, 14'h21}) begin failures++; $display("FAIL sb_wb_req: got v=%b bank=%0d addr=%h want 1/1/21", wb_valid, wb_bank, wb_addr); end
        checks++;
        if (wb_data !== {gold_ecc(clean[1]), clean[1]}) begin failures++; $display("FAIL sb_wb_data: got %h want %h", wb_data, {gold_ecc(clean[1]), clean[1]}); end
        wb_ready = 1'b1;
        model_clock();
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("FAIL sb_popped: got %b want 0", wb_valid); end
        checks++;
        if (sec_count !== 16'd1) begin failures++; $display("FAIL sb_count: got %0d want 1", sec_count); end
    endtask

    task automatic test_overflow();
        idle(); wb_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            idle(); drive_bank(0, 1, i, -1); #1; model_clock();
        end
        idle(); drive_bank(0, 1, 4, -1); drive_bank(1, 1, 5, -1); #1;
        model_clock();
        idle(); #1;
        checks++;
        if (corr_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", corr_overflow); end
        wb_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({wb_valid, wb_bank, wb_addr} !== {1'b1, 1'b0, 14'(i)})
                begin failures++; $display("FAIL ovf_drain%0d: got v=%b bank=%0d addr=%h want 1/0/%0h", i, wb_valid, wb_bank, wb_addr, i); end
            model_clock();
        end
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("FAIL ovf_bank1_dropped: got wb_valid=%b addr=%h want 0", wb_valid, wb_addr); end
    endtask

    task automatic test_kill();
        idle(); wb_ready = 1'b0;
        drive_bank(0, 1, 'h12, -1); #1;
        model_clock();
        idle(); #1;
        checks++;
        if ({wb_valid, wb_addr} !== {1'b1, 14'h12}) begin failures++; $display("FAIL kill_pending: got v=%b addr=%h want 1/12", wb_valid, wb_addr); end
        st_wr_valid = 1'b1; st_wr_bank = 1'b0; st_wr_addr = 14'h12; wb_ready = 1'b1;
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("FAIL kill_same_cycle: got %b want 0", wb_valid); end
        model_clock();
        idle(); wb_ready = 1'b0;
        drive_bank(1, 1, 'h34, -1); #1;
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("FAIL kill_retire: got %b want 0", wb_valid); end
        model_clock();
        idle(); #1;
        checks++;
        if ({wb_valid, wb_bank, wb_addr} !== {1'b1, 1'b1, 14'h34}) begin failures++; $display("FAIL kill_next_head: got v=%b bank=%0d addr=%h want 1/1/34", wb_valid, wb_bank, wb_addr); end
        wb_ready = 1'b1;
        model_clock();
    endtask

    task automatic test_double_fault();
        idle();
        drive_bank(0, 2, 'h40, -1); rd_fault = 1'b1;
        #1;
        checks++;
        if ({double_err, single_err, any_double} !== 5'b01_00_1) begin failures++; $display("FAIL ded_flags: got de=%b se=%b any=%b want 01/00/1", double_err, single_err, any_double); end
        model_clock();
        idle(); #1;
        checks++;
        if (wb_valid !== 1'b0) begin failures++; $display("FAIL ded_no_enqueue: got %b want 0", wb_valid); end
        checks++;
        if (ded_count !== 16'd1) begin failures++; $display("FAIL ded_count: got %0d want 1", ded_count); end
    endtask

    task automatic test_irq();
        idle(); cnt_clr = 1'b1; #1;
        model_clock();
        err_thresh = 16'd3; wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(); drive_bank(0, 1, 'h50 + i, -1); #1;
            model_clock();
            checks++;
            if ({sec_count, err_irq} !== {16'(i + 1), (i == 2)}) begin failures++; $display("FAIL irq_step%0d: got cnt=%0d irq=%b want %0d/%b", i, sec_count, err_irq, i + 1, (i == 2)); end
        end
        idle(); drive_bank(0, 1, 'h60, -1); cnt_clr = 1'b1; #1;
        model_clock();
        checks++;
        if ({sec_count, err_irq, corr_overflow} !== {16'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL irq_clr: got cnt=%0d irq=%b ovf=%b want 0/0/0", sec_count, err_irq, corr_overflow); end
    endtask

    task automatic test_disable();
        idle(); ecc_disable = 1'b1;
        drive_bank(0, 1, 'h70, -1); drive_bank(1, 2, 'h71, -1);
        #1;
        checks++;
        if (sec_data !== rd_data) begin failures++; $display("FAIL dis_data: got %h want %h", sec_data, rd_data); end
        checks++;
        if ({single_err, double_err, any_single, any_double} !== 6'b0) begin failures++; $display("FAIL dis_flags: got se=%b de=%b want 0", single_err, double_err); end
        model_clock();
        idle(); #1;
        checks++;
        if ({sec_count, ded_count, wb_valid} !== {16'(m_sec), 16'(m_ded), 1'b0}) begin failures++; $display("FAIL dis_counts: got %0d/%0d v=%b want %0d/%0d/0", sec_count, ded_count, wb_valid, m_sec, m_ded); end
    endtask

    task automatic test_reset_mid();
        idle(); wb_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle(); drive_bank(i, 1, 'h80 + i, -1); #1; model_clock();
        end
        idle(); #1;
        checks++;
        if (wb_valid !== 1'b1) begin failures++; $display("FAIL rmid_pending: got %b want 1", wb_valid); end
        rst = 1'b1; #1;
        model_reset();
        checks++;
        if ({wb_valid, sec_count} !== {1'b0, 16'd0}) begin failures++; $display("FAIL rmid_cleared: got v=%b cnt=%0d want 0/0", wb_valid, sec_count); end
        @(posedge clk); #1;
        rst = 1'b0; wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (wb_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_write%0d: got %b want 0", i, wb_valid); end
            model_clock();
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] es, ed;
        logic [31:0]   exp_d;
        bit            ev;
        err_thresh = 16'd5;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            ecc_disable = ($urandom_range(0, 9) == 0);
            rd_fault    = ($urandom_range(0, 7) == 0);
            cnt_clr     = ($urandom_range(0, 19) == 0);
            wb_ready    = 1'($urandom_range(0, 1));
            st_wr_valid = ($urandom_range(0, 2) == 0);
            st_wr_bank  = 1'($urandom_range(0, 1));
            st_wr_addr  = AW'($urandom_range(0, 3));
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 3) != 0) drive_bank(b, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
            #1;
            for (int b = 0; b < NB; b++) begin
                es[b] = exp_single(b);
                ed[b] = exp_double(b);
            end
            checks++;
            if ({single_err, double_err} !== {es, ed}) begin failures++; $display("FAIL rnd_flags c%0d: got se=%b de=%b want %b/%b", cyc, single_err, double_err, es, ed); end
            for (int b = 0; b < NB; b++) begin
                if (!exp_double(b)) begin
                    exp_d = en_bank(b) ? clean[b] : rd_data[b*32 +: 32];
                    checks++;
                    if (sec_data[b*32 +: 32] !== exp_d) begin failures++; $display("FAIL rnd_data c%0d b%0d: got %h want %h", cyc, b, sec_data[b*32 +: 32], exp_d); end
                end
            end
            ev = (mq.size() > 0) && mq[0].vld && !st_match(mq[0].bank, mq[0].addr);
            checks++;
            if (wb_valid !== ev) begin failures++; $display("FAIL rnd_wb_valid c%0d: got %b want %b", cyc, wb_valid, ev); end
            if (ev) begin
                checks++;
                if ({wb_bank, wb_addr, wb_data} !== {1'(mq[0].bank), mq[0].addr, gold_ecc(mq[0].data), mq[0].data})
                    begin failures++; $display("FAIL rnd_wb_entry c%0d: got %0d/%h/%h want %0d/%h/%h", cyc, wb_bank, wb_addr, wb_data, mq[0].bank, mq[0].addr, {gold_ecc(mq[0].data), mq[0].data}); end
            end
            checks++;
            if ({sec_count, ded_count, corr_overflow, err_irq} !== {16'(m_sec), 16'(m_ded), m_ovf, m_irq})
                begin failures++; $display("FAIL rnd_state c%0d: got sec=%0d ded=%0d ovf=%b irq=%b want %0d/%0d/%b/%b", cyc, sec_count, ded_count, corr_overflow, err_irq, m_sec, m_ded, m_ovf, m_irq); end
            model_clock();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; scan_mode = 1'b0; wb_ready = 1'b0; err_thresh = '0;
        st_wr_bank = '0; st_wr_addr = '0; rd_addr = '0; rd_data = '0; rd_ecc = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_single_bank1();
        test_overflow();
        test_kill();
        test_double_fault();
        test_irq();
        test_disable();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
